// File: rtl/ir_pkg.sv
// Shared types and helpers for the IR line-error engine.
package ir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } ir_state_t;

  // Accumulator holds +/-(2^nch - 1)(2^irw - 1) plus a sign bit.
  function automatic int acc_width(input int nch, input int irw);
    return irw + nch + 1;
  endfunction

  function automatic int sum_width(input int nch, input int irw);
    return irw + $clog2(2 * nch) + 1;
  endfunction

  localparam int ACC_W = acc_width(4, 12);
  localparam int SUM_W = sum_width(4, 12);

  // Clamp to the signed range of 'width' bits; caller keeps the low 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int width);
    logic signed [63:0] vMax;
    logic signed [63:0] vMin;
    vMax = (64'sd1 <<< (width - 1)) - 64'sd1;
    vMin = -(64'sd1 <<< (width - 1));
    if (val > vMax) return vMax;
    if (val < vMin) return vMin;
    return val;
  endfunction

endpackage

// File: rtl/ir_iir_filt.sv
// First-order IIR smoother for the line error; bypassed to the raw value when disabled.
module ir_iir_filt
  import ir_pkg::*;
#(
  parameter int ERR_W     = 16,
  parameter int FILT_SHFT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic                    i_filtEn,
  input  logic signed [ERR_W-1:0] i_raw,
  output logic signed [ERR_W-1:0] o_flt
);

  logic signed [ERR_W-1:0] r_flt;
  logic signed [ERR_W:0]   w_diff;
  logic signed [ERR_W:0]   w_step;
  logic signed [ERR_W:0]   w_next;

  // The difference needs one extra bit; the result always lies between flt and raw.
  assign w_diff = $signed({i_raw[ERR_W-1], i_raw}) - $signed({r_flt[ERR_W-1], r_flt});
  assign w_step = w_diff >>> FILT_SHFT;
  assign w_next = $signed({r_flt[ERR_W-1], r_flt}) + w_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt <= '0;
    end else if (i_load) begin
      if (i_filtEn) r_flt <= w_next[ERR_W-1:0];
      else          r_flt <= i_raw;
    end
  end

  assign o_flt = r_flt;

endmodule

// File: rtl/ir_err_engine.sv
// Weighted line-position error from 2*NCH_SIDE IR readings, one channel pair per clock,
// with saturation, optional smoothing and line-presence detection.
module ir_err_engine
  import ir_pkg::*;
#(
  parameter int NCH_SIDE  = 4,
  parameter int IR_W      = 12,
  parameter int ERR_W     = 16,
  parameter int LP_THRESH = 1024,
  parameter int FILT_SHFT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         IR_vld,
  input  logic [2*NCH_SIDE*IR_W-1:0]   IR_vec,
  input  logic                         filt_en,
  output logic signed [ERR_W-1:0]      err_raw,
  output logic                         err_vld,
  output logic                         line_present,
  output logic                         busy,
  output logic                         ovr
);

  localparam int ACC_BITS = acc_width(NCH_SIDE, IR_W);
  localparam int SUM_BITS = sum_width(NCH_SIDE, IR_W);
  localparam int KW       = $clog2(NCH_SIDE + 1);
  localparam int VEC_W    = 2 * NCH_SIDE * IR_W;

  ir_state_t                   r_state;
  logic [VEC_W-1:0]            r_shadow;
  logic signed [ACC_BITS-1:0]  r_acc;
  logic [SUM_BITS-1:0]         r_sum;
  logic [KW-1:0]               r_k;
  logic                        r_vld;
  logic                        r_lp;
  logic                        r_ovr;

  logic [IR_W-1:0]             w_l;
  logic [IR_W-1:0]             w_r;
  logic signed [ACC_BITS-1:0]  w_lExt;
  logic signed [ACC_BITS-1:0]  w_rExt;
  logic signed [ACC_BITS-1:0]  w_term;
  logic [SUM_BITS-1:0]         w_sumNext;
  logic signed [63:0]          w_acc64;
  logic signed [63:0]          w_sat64;
  logic signed [ERR_W-1:0]     w_sat;
  logic signed [ERR_W-1:0]     w_flt;
  logic                        w_load;

  always_comb begin
    w_l = '0;
    w_r = '0;
    for (int i = 0; i < NCH_SIDE; i++) begin
      if (r_k == KW'(i)) begin
        w_l = r_shadow[i*IR_W +: IR_W];
        w_r = r_shadow[(i+NCH_SIDE)*IR_W +: IR_W];
      end
    end
  end

  // Channel k carries weight 2^k; right of centre counts positive.
  assign w_lExt    = $signed({{(ACC_BITS-IR_W){1'b0}}, w_l});
  assign w_rExt    = $signed({{(ACC_BITS-IR_W){1'b0}}, w_r});
  assign w_term    = (w_rExt - w_lExt) <<< r_k;
  assign w_sumNext = r_sum + {{(SUM_BITS-IR_W){1'b0}}, w_r}
                           + {{(SUM_BITS-IR_W){1'b0}}, w_l};

  assign w_acc64 = {{(64-ACC_BITS){r_acc[ACC_BITS-1]}}, r_acc};
  assign w_sat64 = sat_signed(w_acc64, ERR_W);
  assign w_sat   = w_sat64[ERR_W-1:0];
  assign w_load  = (r_state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      r_k      <= '0;
      r_vld    <= 1'b0;
      r_lp     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_ovr <= IR_vld && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (IR_vld) begin
            r_shadow <= IR_vec;
            r_acc    <= '0;
            r_sum    <= '0;
            r_k      <= '0;
            r_state  <= ACC;
          end
        end
        ACC: begin
          r_acc <= r_acc + w_term;
          r_sum <= w_sumNext;
          r_k   <= r_k + 1'b1;
          if (r_k == KW'(NCH_SIDE - 1)) r_state <= FIN;
        end
        FIN: begin
          r_lp    <= (int'(r_sum) > LP_THRESH);
          r_vld   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ir_iir_filt #(
    .ERR_W     (ERR_W),
    .FILT_SHFT (FILT_SHFT)
  ) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_filtEn (filt_en),
    .i_raw    (w_sat),
    .o_flt    (w_flt)
  );

  assign err_raw      = w_flt;
  assign err_vld      = r_vld;
  assign line_present = r_lp;
  assign busy         = (r_state != IDLE);
  assign ovr          = r_ovr;

endmodule

// File: tb/tb_ir_err_engine.sv
// Randomised and directed checks of ir_err_engine against a plain-arithmetic reference model.
module tb_ir_err_engine;

  localparam int NCH  = 4;
  localparam int IRW  = 12;
  localparam int ERRW = 16;
  localparam int LPT  = 1024;
  localparam int SH   = 2;
  localparam int VW   = 2 * NCH * IRW;
  localparam int VW5  = 2 * 5 * IRW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   irVld = 1'b0;
  logic [VW-1:0]          irVec = '0;
  logic                   filtEn = 1'b0;
  logic signed [ERRW-1:0] errRaw;
  logic                   errVld;
  logic                   linePresent;
  logic                   busy;
  logic                   ovr;

  logic                   irVld5 = 1'b0;
  logic [VW5-1:0]         irVec5 = '0;
  logic signed [ERRW-1:0] errRaw5;
  logic                   errVld5;
  logic                   lp5;
  logic                   busy5;
  logic                   ovr5;

  int checkCount = 0;
  int errorCount = 0;
  int mFlt = 0;
  int expRaw = 0;
  bit expLp = 1'b0;

  always #5 clk = ~clk;

  ir_err_engine #(
    .NCH_SIDE(NCH), .IR_W(IRW), .ERR_W(ERRW), .LP_THRESH(LPT), .FILT_SHFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IR_vld(irVld), .IR_vec(irVec), .filt_en(filtEn),
    .err_raw(errRaw), .err_vld(errVld), .line_present(linePresent), .busy(busy), .ovr(ovr)
  );

  ir_err_engine #(
    .NCH_SIDE(5), .IR_W(IRW), .ERR_W(ERRW), .LP_THRESH(LPT), .FILT_SHFT(SH)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .IR_vld(irVld5), .IR_vec(irVec5), .filt_en(1'b0),
    .err_raw(errRaw5), .err_vld(errVld5), .line_present(lp5), .busy(busy5), .ovr(ovr5)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: weighted sum over channels, clamp, then smooth or pass through.
  function automatic void modelStep(input logic [VW-1:0] v, input bit f);
    longint acc = 0;
    longint sum = 0;
    longint l;
    longint r;
    longint raw;
    longint hi = (longint'(1) << (ERRW - 1)) - 1;
    longint lo = -(longint'(1) << (ERRW - 1));
    for (int k = 0; k < NCH; k++) begin
      l = longint'(v[k*IRW +: IRW]);
      r = longint'(v[(k+NCH)*IRW +: IRW]);
      acc += (r - l) * (longint'(1) << k);
      sum += r + l;
    end
    raw = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
    if (f) mFlt = mFlt + ((int'(raw) - mFlt) >>> SH);
    else   mFlt = int'(raw);
    expRaw = mFlt;
    expLp  = (sum > LPT);
  endfunction

  task automatic launch(input logic [VW-1:0] v, input bit f);
    @(negedge clk);
    irVld  = 1'b1;
    irVec  = v;
    filtEn = f;
    @(negedge clk);
    irVld  = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int expLat);
    int cycles = 0;
    while (errVld !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_lat"}, cycles, expLat);
    checkOutput({tag, "_err"}, int'(errRaw), expRaw);
    checkOutput({tag, "_lp"}, int'(linePresent), int'(expLp));
  endtask

  task automatic applyStimulus(input logic [VW-1:0] v, input bit f, input string tag);
    launch(v, f);
    modelStep(v, f);
    waitResult(tag, NCH + 1);
  endtask

  task automatic runFive(input logic [VW5-1:0] v, input int expErr, input string tag);
    int cycles = 0;
    @(negedge clk);
    irVld5 = 1'b1;
    irVec5 = v;
    @(negedge clk);
    irVld5 = 1'b0;
    while (errVld5 !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_lat"}, cycles, 6);
    checkOutput({tag, "_err"}, int'(errRaw5), expErr);
  endtask

  initial begin
    logic [VW-1:0]  vR3;
    logic [VW-1:0]  vL3;
    logic [VW-1:0]  v;
    logic [VW-1:0]  vB;
    logic [VW5-1:0] v5;
    int             cap;
    bit             f;
    int             seen;

    vR3 = '0;
    vR3[(NCH+3)*IRW +: IRW] = 12'hFFF;
    vL3 = '0;
    vL3[3*IRW +: IRW] = 12'hFFF;

    repeat (2) @(negedge clk);
    checkOutput("rst_err", int'(errRaw), 0);
    checkOutput("rst_vld", int'(errVld), 0);
    checkOutput("rst_lp", int'(linePresent), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ovr", int'(ovr), 0);
    rst_n = 1'b1;

    applyStimulus('0, 1'b0, "zero");
    applyStimulus(vR3, 1'b0, "r3");
    checkOutput("r3_const", int'(errRaw), 32760);
    applyStimulus(vL3, 1'b0, "l3");
    checkOutput("l3_const", int'(errRaw), -32760);

    v = '0;
    v[0 +: IRW] = 12'd1024;
    applyStimulus(v, 1'b0, "thr_eq");
    checkOutput("thr_eq_lp", int'(linePresent), 0);
    v[0 +: IRW] = 12'd1025;
    applyStimulus(v, 1'b0, "thr_gt");
    checkOutput("thr_gt_lp", int'(linePresent), 1);

    applyStimulus('0, 1'b0, "clr");
    applyStimulus(vR3, 1'b1, "flt1");
    checkOutput("flt1_const", int'(errRaw), 8190);
    applyStimulus(vR3, 1'b1, "flt2");
    checkOutput("flt2_const", int'(errRaw), 14332);
    applyStimulus(vR3, 1'b1, "flt3");
    checkOutput("flt3_const", int'(errRaw), 18939);

    for (int i = 0; i < 40; i++) begin
      cap = ($urandom_range(0, 3) == 0) ? 100 : 4095;
      for (int c = 0; c < 2 * NCH; c++) v[c*IRW +: IRW] = IRW'($urandom_range(0, cap));
      f = 1'($urandom_range(0, 1));
      applyStimulus(v, f, "rnd");
    end

    // A sample arriving mid-computation is dropped and flagged.
    for (int c = 0; c < 2 * NCH; c++) v[c*IRW +: IRW] = IRW'($urandom_range(0, 4095));
    vB = ~v;
    launch(v, 1'b0);
    modelStep(v, 1'b0);
    @(negedge clk);
    irVld = 1'b1;
    irVec = vB;
    @(negedge clk);
    irVld = 1'b0;
    checkOutput("ovr_hi", int'(ovr), 1);
    @(negedge clk);
    checkOutput("ovr_lo", int'(ovr), 0);
    waitResult("ovr", 2);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (errVld) seen++;
    end
    checkOutput("ovr_single", seen, 0);

    applyStimulus(vL3, 1'b0, "pre_acc");
    irVld  = 1'b1;
    irVec  = vR3;
    filtEn = 1'b0;
    modelStep(vR3, 1'b0);
    @(negedge clk);
    irVld = 1'b0;
    checkOutput("accept_busy", int'(busy), 1);
    checkOutput("accept_ovr", int'(ovr), 0);
    waitResult("accept", NCH + 1);

    applyStimulus(vR3, 1'b0, "pre_rst");
    launch(vL3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_err", int'(errRaw), 0);
    checkOutput("abort_lp", int'(linePresent), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (errVld) seen++;
    end
    checkOutput("abort_novld", seen, 0);
    rst_n = 1'b1;
    mFlt = 0;
    applyStimulus(vR3, 1'b1, "post_rst");
    checkOutput("post_rst_const", int'(errRaw), 8190);

    v5 = '0;
    v5[9*IRW +: IRW] = 12'hFFF;
    runFive(v5, 32767, "n5_pos");
    v5 = '0;
    v5[4*IRW +: IRW] = 12'hFFF;
    runFive(v5, -32768, "n5_neg");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ir_err_engine.md
Name: ir_err_engine

Overview:
- Parametrised successor to the fixed 4+4-channel line-error computation in the line-follower datapath.
- Takes 2*NCH_SIDE IR readings from the IR interface and computes the signed weighted line-position error, with sequential per-channel accumulation, output saturation, optional IIR smoothing and line-presence detection.
- Feeds the error mux ahead of the PID: err_raw when line_present, otherwise the open-loop term.

Parameters:
NCH_SIDE, 4, IR channels per side (1..8); weight of channel k is 2^k
IR_W, 12, bits per IR reading (unsigned)
ERR_W, 16, signed output error width
LP_THRESH, 1024, sum of all channels must exceed this for line_present
FILT_SHFT, 2, IIR smoothing shift (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
IR_vld  in  1  one-cycle strobe: IR_vec valid
IR_vec  in  2*NCH_SIDE*IR_W  packed readings; slice i (i*IR_W LSB) = L_i for i<NCH_SIDE, R_(i-NCH_SIDE) otherwise
filt_en  in  1  1 = smoothed output, 0 = raw
err_raw  out  ERR_W  signed error; positive = line to the right
err_vld  out  1  one-cycle strobe: err_raw and line_present updated
line_present  out  1  line detected on last completed sample
busy  out  1  computation in progress
ovr  out  1  one-cycle pulse: IR_vld dropped while busy

Behaviour:
- Reset (async, rst_n low): err_raw=0, err_vld=0, line_present=0, busy=0, ovr=0. Accumulators, filter state and channel index cleared; FSM to IDLE. Reset mid-computation aborts it and emits no err_vld.
- FSM states: IDLE, ACC, FIN.
- IDLE:
  - On IR_vld=1 at edge E0, capture IR_vec into a shadow register, clear acc and sum, set k=0, go to ACC, busy=1.
- ACC: one channel pair per clock.
  - acc += (R_k - L_k) <<< k and sum += R_k + L_k, then k++.
  - After k=NCH_SIDE-1, go to FIN.
  - Occupies edges E1..E_NCH_SIDE.
- FIN, at edge E_(NCH_SIDE+1):
  - raw = saturate(acc) to ERR_W signed, clamped to [-2^(ERR_W-1), 2^(ERR_W-1)-1].
  - If filt_en=1: flt = flt + ((raw - flt) >>> FILT_SHFT), arithmetic shift, with the difference computed one bit wider than ERR_W. err_raw = flt.
  - If filt_en=0: flt = raw, err_raw = raw.
  - line_present = (sum > LP_THRESH).
  - err_vld=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: err_vld high in the cycle after E_(NCH_SIDE+1). With the default parameters that is 5 clocks after IR_vld was sampled. A new IR_vld is accepted in the cycle that err_vld is high.
- Widths:
  - acc width = IR_W + NCH_SIDE + 1 signed (covers ±(2^NCH_SIDE - 1)(2^IR_W - 1)).
  - sum width = IR_W + clog2(2*NCH_SIDE) + 1 unsigned.
- IR_vld while busy (ACC or FIN): sample dropped, capture register unchanged, ovr pulses for 1 cycle, no effect on the computation in flight.
- err_raw and line_present hold between err_vld pulses.
- filt_en change: takes effect at the next FIN. When going 0→1, the filter starts from the last raw value.

Decomposition:
- ir_pkg holds:
  - enum ir_state_t {IDLE, ACC, FIN}
  - localparams for ACC_W and SUM_W as functions of NCH_SIDE/IR_W
  - function sat_signed(acc) -> ERR_W
- One sub-module: ir_iir_filt (flt register, shift-subtract-add, filt_en bypass), instantiated once.
- FSM, index counter and accumulators stay in ir_err_engine.

Test Plan:
1. Defaults, IR_vec all zero, IR_vld pulse -> err_vld 5 clocks later, err_raw=0, line_present=0.
2. R3=0xFFF, others 0, filt_en=0 -> err_raw=32760 (0x7FF8), line_present=1 (sum 4095>1024). L3=0xFFF only -> err_raw=-32760.
3. NCH_SIDE=5, R4=0xFFF only -> unsaturated 65520, err_raw=32767. L4=0xFFF only -> -32768.
4. filt_en=1, FILT_SHFT=2, flt=0, three samples with raw=32760 -> err_raw 8190, 14332, 18939.
5. IR_vld pulsed 2 clocks after an accepted IR_vld -> ovr one-cycle pulse, exactly one err_vld with the first sample's result. IR_vld in the err_vld cycle -> accepted, busy=1 next cycle.
6. rst_n low during ACC (k=2) -> all outputs 0 immediately, no err_vld. After release, a fresh sample completes normally with flt starting from 0.
